// File: rtl/down_counter_mod_m_reload.sv
// Loadable mod-M down-counter/timer with one-shot and auto-reload modes and a registered done pulse.
// Optional sticky completion flag with acknowledge when DOWN_CNT_STICKY_EN is defined.
module down_counter_mod_m_reload #(
  parameter int M = 20,
  localparam int N = $clog2(M)
) (
  input  logic         clk,
  input  logic         sclr,
  input  logic         load,
  input  logic [N-1:0] load_val,
  input  logic         periodic,
  input  logic         start,
  input  logic         stop,
  input  logic         tick,
  output logic [N-1:0] Q,
  output logic         busy,
  output logic         paused,
  output logic         done
`ifdef DOWN_CNT_STICKY_EN
  ,
  output logic         done_flag,
  input  logic         done_ack
`endif
);

  typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;

  localparam logic [N-1:0] MaxVal = N'(M - 1);
  localparam logic [N-1:0] One    = N'(1);

  state_t       state, state_next;
  logic [N-1:0] reload, reload_next;
  logic [N-1:0] q_next;
  logic [N-1:0] clamped;
  logic         done_next;

  assign clamped = (load_val > MaxVal) ? MaxVal : load_val;

  always_ff @(posedge clk) begin
    if (sclr) begin
      state  <= IDLE;
      Q      <= '0;
      reload <= '0;
      done   <= 1'b0;
    end else begin
      state  <= state_next;
      Q      <= q_next;
      reload <= reload_next;
      done   <= done_next;
    end
  end

  // Priority below sclr: load, then stop, then start, then tick.
  always_comb begin
    state_next  = state;
    q_next      = Q;
    reload_next = reload;
    done_next   = 1'b0;
    if (load) begin
      q_next      = clamped;
      reload_next = clamped;
      if (clamped == '0) state_next = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (start && Q != '0) state_next = RUN;
        end
        RUN: begin
          if (stop) begin
            state_next = HOLD;
          end else if (tick) begin
            if (Q > One) begin
              q_next = Q - One;
            end else if (Q == One) begin
              done_next = 1'b1;
              if (periodic) begin
                q_next = reload;
              end else begin
                q_next     = '0;
                state_next = IDLE;
              end
            end else begin
              state_next = IDLE;
            end
          end
        end
        HOLD: begin
          if (start) state_next = RUN;
        end
        default: state_next = IDLE;
      endcase
    end
  end

  assign busy   = (state == RUN);
  assign paused = (state == HOLD);

`ifdef DOWN_CNT_STICKY_EN
  // Flag rises together with done; a simultaneous acknowledge loses to the new event.
  always_ff @(posedge clk) begin
    if (sclr)           done_flag <= 1'b0;
    else if (done_next) done_flag <= 1'b1;
    else if (done_ack)  done_flag <= 1'b0;
  end
`endif

endmodule

// File: tb/tb_down_counter_mod_m_reload.sv
// Self-checking bench for down_counter_mod_m_reload: directed scenarios then random traffic
// against a behavioural model; exercises the sticky flag when DOWN_CNT_STICKY_EN is defined.
module tb_down_counter_mod_m_reload;
  localparam int M = 20;
  localparam int N = $clog2(M);

  logic         clk = 1'b0;
  logic         sclr = 1'b0, load = 1'b0, periodic = 1'b0, start = 1'b0, stop = 1'b0, tick = 1'b0;
  logic [N-1:0] load_val = '0;
  logic [N-1:0] Q;
  logic         busy, paused, done;
`ifdef DOWN_CNT_STICKY_EN
  logic         done_flag;
  logic         done_ack = 1'b0;
  bit           mFlag = 1'b0;
`endif

  int  total = 0;
  int  bad = 0;
  int  mq = 0;
  int  mReload = 0;
  byte mMode = "I";
  bit  mDone = 1'b0;

  down_counter_mod_m_reload #(.M(M)) dut (
    .clk(clk), .sclr(sclr), .load(load), .load_val(load_val), .periodic(periodic),
    .start(start), .stop(stop), .tick(tick), .Q(Q), .busy(busy), .paused(paused), .done(done)
`ifdef DOWN_CNT_STICKY_EN
    , .done_flag(done_flag), .done_ack(done_ack)
`endif
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag);
    total++;
    assert (int'(Q) === mq) else begin
      bad++; $error("FAIL %s.Q got=%0d exp=%0d", tag, Q, mq);
    end
    total++;
    assert (busy === (mMode == "R")) else begin
      bad++; $error("FAIL %s.busy got=%0b exp=%0b", tag, busy, mMode == "R");
    end
    total++;
    assert (paused === (mMode == "H")) else begin
      bad++; $error("FAIL %s.paused got=%0b exp=%0b", tag, paused, mMode == "H");
    end
    total++;
    assert (done === mDone) else begin
      bad++; $error("FAIL %s.done got=%0b exp=%0b", tag, done, mDone);
    end
`ifdef DOWN_CNT_STICKY_EN
    total++;
    assert (done_flag === mFlag) else begin
      bad++; $error("FAIL %s.done_flag got=%0b exp=%0b", tag, done_flag, mFlag);
    end
`endif
  endtask

  // One clock of stimulus; the model applies the documented rules to the values sampled at the edge.
  task automatic applyStimulus(input string tag, input bit s, input bit ld, input int v,
                               input bit per, input bit st, input bit sp, input bit tk);
    int c;
    sclr = s; load = ld; load_val = N'(v); periodic = per; start = st; stop = sp; tick = tk;
    @(posedge clk);
    mDone = 1'b0;
    if (s) begin
      mq = 0; mReload = 0; mMode = "I";
    end else if (ld) begin
      c = (v > M - 1) ? M - 1 : v;
      mq = c; mReload = c;
      if (c == 0) mMode = "I";
    end else if (mMode == "R") begin
      if (sp) mMode = "H";
      else if (tk) begin
        if (mq == 1) begin
          mDone = 1'b1;
          if (per) mq = mReload;
          else begin mq = 0; mMode = "I"; end
        end else if (mq > 1) mq = mq - 1;
      end
    end else if (mMode == "I") begin
      if (st && mq != 0) mMode = "R";
    end else if (st) begin
      mMode = "R";
    end
`ifdef DOWN_CNT_STICKY_EN
    if (s) mFlag = 1'b0;
    else if (mDone) mFlag = 1'b1;
    else if (done_ack) mFlag = 1'b0;
`endif
    #1;
    checkOutput(tag);
  endtask

  initial begin
    $display("[TB] start, M=%0d N=%0d", M, N);
    applyStimulus("rst0", 1, 0, 0, 0, 0, 0, 0);
    applyStimulus("rst1", 1, 0, 0, 0, 0, 0, 0);
    applyStimulus("startQ0", 0, 0, 0, 0, 1, 0, 1);

    applyStimulus("ld5", 0, 1, 5, 0, 0, 0, 0);
    applyStimulus("go5", 0, 0, 0, 0, 1, 0, 0);
    for (int i = 0; i < 6; i++) applyStimulus("oneshot", 0, 0, 0, 0, 0, 0, 1);

    applyStimulus("ld3", 0, 1, 3, 1, 0, 0, 0);
    applyStimulus("go3", 0, 0, 0, 1, 1, 0, 0);
    for (int i = 0; i < 9; i++) applyStimulus("periodic", 0, 0, 0, 1, 0, 0, 1);
    applyStimulus("ld0inRun", 0, 1, 0, 1, 0, 0, 1);

    applyStimulus("ld25clamp", 0, 1, 25, 0, 0, 0, 0);
    applyStimulus("go19", 0, 0, 0, 0, 1, 0, 0);
    for (int i = 0; i < 9; i++) applyStimulus("to10", 0, 0, 0, 0, 0, 0, 1);
    applyStimulus("stopTick", 0, 0, 0, 0, 0, 1, 1);
    applyStimulus("holdTick", 0, 0, 0, 0, 0, 0, 1);
    applyStimulus("resume", 0, 0, 0, 0, 1, 0, 0);
    applyStimulus("resTick", 0, 0, 0, 0, 0, 0, 1);

    applyStimulus("to7a", 0, 0, 0, 0, 0, 0, 1);
    applyStimulus("to7b", 0, 0, 0, 0, 0, 0, 1);
    applyStimulus("ldTick", 0, 1, 2, 0, 0, 0, 1);
    applyStimulus("to1", 0, 0, 0, 0, 0, 0, 1);
    applyStimulus("sclrAt1", 1, 0, 0, 0, 0, 0, 1);
    applyStimulus("noDone", 0, 0, 0, 0, 0, 0, 1);

    applyStimulus("ld1", 0, 1, 1, 1, 0, 0, 0);
    applyStimulus("go1", 0, 0, 0, 1, 1, 0, 0);
    for (int i = 0; i < 3; i++) applyStimulus("reload1", 0, 0, 0, 1, 0, 0, 1);
    applyStimulus("startInRun", 0, 0, 0, 1, 1, 0, 0);
    applyStimulus("ldHold", 0, 0, 0, 1, 0, 1, 0);
    applyStimulus("ldInHold", 0, 1, 4, 1, 0, 0, 1);
    applyStimulus("stopInHold", 0, 0, 0, 1, 0, 1, 0);

`ifdef DOWN_CNT_STICKY_EN
    applyStimulus("sRst", 1, 0, 0, 0, 0, 0, 0);
    applyStimulus("sLd", 0, 1, 2, 0, 0, 0, 0);
    applyStimulus("sGo", 0, 0, 0, 0, 1, 0, 0);
    applyStimulus("sT1", 0, 0, 0, 0, 0, 0, 1);
    done_ack = 1'b1;
    applyStimulus("sAckSet", 0, 0, 0, 0, 0, 0, 1);
    done_ack = 1'b0;
    applyStimulus("sHold", 0, 0, 0, 0, 0, 0, 0);
    done_ack = 1'b1;
    applyStimulus("sAck", 0, 0, 0, 0, 0, 0, 0);
    done_ack = 1'b0;
`endif

    for (int i = 0; i < 400; i++) begin
`ifdef DOWN_CNT_STICKY_EN
      done_ack = ($urandom_range(0, 9) == 0);
`endif
      applyStimulus("rand", $urandom_range(0, 49) == 0, $urandom_range(0, 9) == 0,
                    int'($urandom_range(0, 31)), $urandom_range(0, 1) == 1,
                    $urandom_range(0, 4) == 0, $urandom_range(0, 9) == 0,
                    $urandom_range(0, 9) < 6);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
